// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings, FSM state type and lane helpers for mem_access_unit.
// The optional misaligned-access trap is enabled with the MISALIGN_TRAP_EN macro
// (see mem_access_unit.sv); nothing in this package depends on it.
package mau_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;   // 2'b11 is also treated as a word

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } mau_state_t;

   // Replace the addressed byte/half lane of 'word' with the low bits of 'data'.
   // Word sizes (including 2'b11) replace the whole word.
   function automatic logic [31:0] merge_lanes(
      input logic [31:0] word,
      input logic [31:0] data,
      input logic [1:0]  size,
      input logic [1:0]  lane
   );
      logic [31:0] res;
      res = word;
      case (size)
         SZ_BYTE: res[{lane, 3'b000} +: 8]        = data[7:0];
         SZ_HALF: res[{lane[1], 4'b0000} +: 16]   = data[15:0];
         default: res                              = data;
      endcase
      return res;
   endfunction

   // True when the size/low-address combination is not naturally aligned.
   function automatic logic is_misaligned(
      input logic [1:0] size,
      input logic [1:0] adr_lo
   );
      logic bad;
      bad = 1'b0;
      if (size == SZ_HALF)
         bad = adr_lo[0];
      else if (size[1])
         bad = (adr_lo != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// mau_load_align: combinational load lane select with sign/zero extension.
// Word sizes pass the memory word through unchanged.
module mau_load_align
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sext,
   output logic [31:0] data
);

   logic [7:0]  byte_lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Split the word into its four little-endian byte lanes.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = word[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = byte_lane[lane];
   assign half_sel = lane[1] ? word[31:16] : word[15:0];

   // Extend the selected lane to 32 bits according to sext.
   always_comb begin
      data = word;
      case (size)
         SZ_BYTE: data = {{24{sext & byte_sel[7]}}, byte_sel};
         SZ_HALF: data = {{16{sext & half_sel[15]}}, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: converts CPU byte/half/word loads and stores into aligned
// word accesses on a data memory without byte enables. Sub-word stores run as
// a read-modify-write: one stalled read cycle, then a write cycle from wbuf.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses on
// 'misalign' and suppress them; otherwise offending low address bits are ignored.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] d_in,
   input  logic          mrd,
   input  logic          mwr,
   input  logic [1:0]    size,
   input  logic          sext,
   output logic [DW-1:0] d_out,
   output logic          stall,
   output logic          misalign,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_d_in,
   output logic          mem_mrd,
   output logic          mem_mwr,
   input  logic [DW-1:0] mem_d_out
);

   mau_state_t    state_reg, state_next;
   logic [DW-1:0] wbuf_reg,  wbuf_next;
   logic [AW-1:0] adr_reg,   adr_next;    // word address of the store in flight

   logic [AW-1:0] word_adr;
   logic [1:0]    lane;
   logic          misalign_det;
   logic          misalign_c;
   logic          load_en;
   logic          stall_c;
   logic          mem_mrd_c;
   logic          mem_mwr_c;
   logic [DW-1:0] load_data;

   assign word_adr = {adr[AW-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
   assign misalign_det = is_misaligned(size, adr[1:0]);
   assign lane         = adr[1:0];
`else
   assign misalign_det = 1'b0;
   // Ignore low bits that an aligned access of this size cannot use.
   assign lane = (size == SZ_BYTE) ? adr[1:0] :
                 (size == SZ_HALF) ? {adr[1], 1'b0} : 2'b00;
`endif

   mau_load_align u_load_align (
      .word (mem_d_out),
      .size (size),
      .lane (lane),
      .sext (sext),
      .data (load_data)
   );

   // State, write buffer and held store address; reset aborts any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         wbuf_reg  <= '0;
         adr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         wbuf_reg  <= wbuf_next;
         adr_reg   <= adr_next;
      end
   end

   // Next-state logic and memory strobe muxing; stores take priority over loads.
   always_comb begin
      state_next = state_reg;
      wbuf_next  = wbuf_reg;
      adr_next   = adr_reg;
      stall_c    = 1'b0;
      mem_mrd_c  = 1'b0;
      mem_mwr_c  = 1'b0;
      misalign_c = 1'b0;
      load_en    = 1'b0;
      mem_adr    = word_adr;
      mem_d_in   = d_in;
      case (state_reg)
         IDLE: begin
            if (mwr) begin
               if (misalign_det) begin
                  misalign_c = 1'b1;
               end else if (size[1]) begin
                  mem_mwr_c = 1'b1;
               end else begin
                  // Read phase of the read-modify-write: merge into wbuf now.
                  stall_c    = 1'b1;
                  mem_mrd_c  = 1'b1;
                  wbuf_next  = merge_lanes(mem_d_out, d_in, size, lane);
                  adr_next   = word_adr;
                  state_next = RMW_WR;
               end
            end else if (mrd) begin
               if (misalign_det) begin
                  misalign_c = 1'b1;
               end else begin
                  mem_mrd_c = 1'b1;
                  load_en   = 1'b1;
               end
            end
         end
         RMW_WR: begin
            // Write phase; the CPU still presents the same store, so inputs are ignored.
            mem_mwr_c  = 1'b1;
            mem_d_in   = wbuf_reg;
            mem_adr    = adr_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // All control outputs are forced low while reset is held.
   assign stall    = stall_c    & rst_n;
   assign mem_mrd  = mem_mrd_c  & rst_n;
   assign mem_mwr  = mem_mwr_c  & rst_n;
   assign misalign = misalign_c & rst_n;
   assign d_out    = (load_en & rst_n) ? load_data : '0;

endmodule
